// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci display: timer state encodings and
// the default 1 ms prescale used by every timer channel.
package fib_pkg;

    localparam int unsigned FIB_PRESCALE_1MS = 12000;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_RUN  = 2'd1,
        TMR_DONE = 2'd2
    } tmr_state_e;

    // Prescale counter width: clog2(p), never below one bit.
    function automatic int unsigned prescale_width(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescale counter: free-runs while enabled and flags the PRESCALE-1 -> 0 wrap
// as a single-cycle combinational tick.
module tick_gen
    import fib_pkg::*;
#(
    parameter int unsigned PRESCALE = FIB_PRESCALE_1MS
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_c_o
);

    localparam int unsigned PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_c_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/delay_timer.sv
// Programmable one-shot delay timer: counts ticks_in prescaled ticks, then
// holds int_out until the controller restarts or aborts it.
module delay_timer
    import fib_pkg::*;
#(
    parameter int unsigned PRESCALE    = FIB_PRESCALE_1MS,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic [COUNT_WIDTH-1:0] ticks_in,
    output logic                   int_out,
    output logic                   busy_out,
    output logic [COUNT_WIDTH-1:0] remaining_out
);

    if (PRESCALE == 0 || COUNT_WIDTH == 0) begin : g_param_check
        $error("delay_timer: PRESCALE and COUNT_WIDTH must both be at least 1");
    end

    tmr_state_e             state_q;
    tmr_state_e             state_d;
    logic                   int_q;
    logic                   int_d;
    logic                   busy_q;
    logic                   busy_d;
    logic [COUNT_WIDTH-1:0] rem_q;
    logic [COUNT_WIDTH-1:0] rem_d;
    logic                   tick_c;
    logic                   zero_len_c;

    assign zero_len_c = (ticks_in == '0);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .clear_i  (start_in || abort_in),
        .enable_i (state_q == TMR_RUN),
        .tick_c_o (tick_c)
    );

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q <= TMR_IDLE;
            int_q   <= 1'b0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
        end
    end

    // Priority in every state: abort, then start, then expiry.
    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = TMR_IDLE;
        end else if (start_in) begin
            state_d = zero_len_c ? TMR_DONE : TMR_RUN;
        end else begin
            case (state_q)
                TMR_IDLE: state_d = TMR_IDLE;
                TMR_RUN:  state_d = (tick_c && rem_q == COUNT_WIDTH'(1)) ? TMR_DONE : TMR_RUN;
                TMR_DONE: state_d = TMR_DONE;
                default:  state_d = TMR_IDLE;
            endcase
        end
    end

    always_comb begin
        int_d  = (state_d == TMR_DONE);
        busy_d = (state_d == TMR_RUN);
        rem_d  = rem_q;
        if (abort_in) begin
            rem_d = '0;
        end else if (start_in) begin
            rem_d = ticks_in;
        end else if (state_q == TMR_RUN && tick_c && rem_q != '0) begin
            rem_d = rem_q - COUNT_WIDTH'(1);
        end else if (state_q != TMR_RUN) begin
            rem_d = '0;
        end
    end

    assign int_out       = int_q;
    assign busy_out      = busy_q;
    assign remaining_out = rem_q;

endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer: two instances (PRESCALE 4 and 1), expected
// outputs queued per edge by the stimulus and checked by a negedge monitor.
module tb_delay_timer;

    typedef struct {
        int         e;
        string      nm;
        logic       i;
        logic       b;
        logic [7:0] r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, abort4 = 1'b0;
    logic [7:0] ticks4 = 8'd0;
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [7:0] ticks1 = 8'd0;
    logic       int4, busy4, int1, busy1;
    logic [7:0] rem4, rem1;

    int   ecount = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    delay_timer #(.PRESCALE(4), .COUNT_WIDTH(8)) u_dut4 (
        .clock_in (clk), .reset_in (rst_n), .start_in (start4), .abort_in (abort4),
        .ticks_in (ticks4), .int_out (int4), .busy_out (busy4), .remaining_out (rem4)
    );

    delay_timer #(.PRESCALE(1), .COUNT_WIDTH(8)) u_dut1 (
        .clock_in (clk), .reset_in (rst_n), .start_in (start1), .abort_in (abort1),
        .ticks_in (ticks1), .int_out (int1), .busy_out (busy1), .remaining_out (rem1)
    );

    task automatic check(input exp_t x, input logic i, input logic b, input logic [7:0] r);
        n_cmp++;
        if (i !== x.i || b !== x.b || r !== x.r) begin
            n_bad++;
            $display("FAIL %s edge %0d: got int=%b busy=%b rem=%0d, want int=%b busy=%b rem=%0d",
                     x.nm, x.e, i, b, r, x.i, x.b, x.r);
        end
    endtask

    // Monitor: compare every queued expectation whose edge has just passed.
    always @(negedge clk) begin : monitor
        exp_t x;
        while (q4.size() > 0 && q4[0].e <= ecount) begin
            x = q4.pop_front();
            if (x.e < ecount) begin
                n_cmp++; n_bad++;
                $display("FAIL %s edge %0d: expectation skipped, now edge %0d", x.nm, x.e, ecount);
            end else begin
                check(x, int4, busy4, rem4);
            end
        end
        while (q1.size() > 0 && q1[0].e <= ecount) begin
            x = q1.pop_front();
            if (x.e < ecount) begin
                n_cmp++; n_bad++;
                $display("FAIL %s edge %0d: expectation skipped, now edge %0d", x.nm, x.e, ecount);
            end else begin
                check(x, int1, busy1, rem1);
            end
        end
    end

    task automatic seg(input int dut, input string nm, input int b, input int from, input int to,
                       input logic i, input logic bz, input logic [7:0] r);
        exp_t x;
        for (int e = from; e <= to; e++) begin
            x.e = b + e; x.nm = nm; x.i = i; x.b = bz; x.r = r;
            if (dut == 4) q4.push_back(x);
            else          q1.push_back(x);
        end
    endtask

    task automatic wait_edge(input int e);
        while (ecount < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present inputs just after edge e-1 so they are sampled at edge e.
    task automatic pulse4(input int e, input logic s, input logic a, input logic [7:0] t);
        wait_edge(e - 1);
        start4 = s; abort4 = a; ticks4 = t;
        wait_edge(e);
        start4 = 1'b0; abort4 = 1'b0;
    endtask

    task automatic pulse1(input int e, input logic s, input logic a, input logic [7:0] t);
        wait_edge(e - 1);
        start1 = s; abort1 = a; ticks1 = t;
        wait_edge(e);
        start1 = 1'b0; abort1 = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", ecount);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int b;
        seg(4, "reset", 0, 1, 5, 1'b0, 1'b0, 8'd0);
        seg(1, "reset1", 0, 1, 5, 1'b0, 1'b0, 8'd0);
        wait_edge(3);
        rst_n = 1'b1;

        // Basic: N=3 from edge 10, then abort in DONE.
        b = ecount + 3;
        seg(4, "basic_idle", b, 0, 9, 1'b0, 1'b0, 8'd0);
        seg(4, "basic_r3", b, 10, 13, 1'b0, 1'b1, 8'd3);
        seg(4, "basic_r2", b, 14, 17, 1'b0, 1'b1, 8'd2);
        seg(4, "basic_r1", b, 18, 21, 1'b0, 1'b1, 8'd1);
        seg(4, "basic_done", b, 22, 24, 1'b1, 1'b0, 8'd0);
        seg(4, "abort_done", b, 25, 26, 1'b0, 1'b0, 8'd0);
        pulse4(b + 10, 1'b1, 1'b0, 8'd3);
        pulse4(b + 25, 1'b0, 1'b1, 8'd0);
        wait_edge(b + 27);

        // Zero-length start, hold, then N=1 restart out of DONE.
        b = ecount + 3;
        seg(4, "zero_idle", b, 0, 4, 1'b0, 1'b0, 8'd0);
        seg(4, "zero_hold", b, 5, 24, 1'b1, 1'b0, 8'd0);
        seg(4, "zero_n1", b, 25, 28, 1'b0, 1'b1, 8'd1);
        seg(4, "zero_n1_done", b, 29, 31, 1'b1, 1'b0, 8'd0);
        seg(4, "zero_abort", b, 32, 33, 1'b0, 1'b0, 8'd0);
        pulse4(b + 5, 1'b1, 1'b0, 8'd0);
        pulse4(b + 25, 1'b1, 1'b0, 8'd1);
        pulse4(b + 32, 1'b0, 1'b1, 8'd0);
        wait_edge(b + 34);

        // Restart mid-run: N=5 at 0, N=2 at 7, expiry at 15.
        b = ecount + 3;
        seg(4, "rst_r5", b, 0, 3, 1'b0, 1'b1, 8'd5);
        seg(4, "rst_r4", b, 4, 6, 1'b0, 1'b1, 8'd4);
        seg(4, "rst_re2", b, 7, 10, 1'b0, 1'b1, 8'd2);
        seg(4, "rst_re1", b, 11, 14, 1'b0, 1'b1, 8'd1);
        seg(4, "rst_done", b, 15, 22, 1'b1, 1'b0, 8'd0);
        seg(4, "rst_abort", b, 23, 24, 1'b0, 1'b0, 8'd0);
        pulse4(b + 0, 1'b1, 1'b0, 8'd5);
        pulse4(b + 7, 1'b1, 1'b0, 8'd2);
        pulse4(b + 23, 1'b0, 1'b1, 8'd0);
        wait_edge(b + 25);

        // Abort beats start in RUN and in IDLE.
        b = ecount + 3;
        seg(4, "prio_run", b, 0, 2, 1'b0, 1'b1, 8'd5);
        seg(4, "prio_abort", b, 3, 23, 1'b0, 1'b0, 8'd0);
        pulse4(b + 0, 1'b1, 1'b0, 8'd5);
        pulse4(b + 3, 1'b1, 1'b1, 8'd7);
        pulse4(b + 22, 1'b1, 1'b1, 8'd9);
        wait_edge(b + 24);

        // Reset mid-run, then a fresh N=2 run.
        b = ecount + 3;
        seg(4, "rstmid_r4", b, 0, 3, 1'b0, 1'b1, 8'd4);
        seg(4, "rstmid_r3", b, 4, 5, 1'b0, 1'b1, 8'd3);
        seg(4, "rstmid_clr", b, 6, 25, 1'b0, 1'b0, 8'd0);
        seg(4, "post_r2", b, 26, 29, 1'b0, 1'b1, 8'd2);
        seg(4, "post_r1", b, 30, 33, 1'b0, 1'b1, 8'd1);
        seg(4, "post_done", b, 34, 35, 1'b1, 1'b0, 8'd0);
        seg(4, "post_abort", b, 36, 36, 1'b0, 1'b0, 8'd0);
        pulse4(b + 0, 1'b1, 1'b0, 8'd4);
        wait_edge(b + 5);
        rst_n = 1'b0;
        wait_edge(b + 6);
        rst_n = 1'b1;
        pulse4(b + 26, 1'b1, 1'b0, 8'd2);
        pulse4(b + 36, 1'b0, 1'b1, 8'd0);
        wait_edge(b + 37);

        // PRESCALE = 1: one tick per edge.
        b = ecount + 3;
        seg(1, "p1_n1", b, 0, 0, 1'b0, 1'b1, 8'd1);
        seg(1, "p1_n1_done", b, 1, 2, 1'b1, 1'b0, 8'd0);
        seg(1, "p1_abort", b, 3, 4, 1'b0, 1'b0, 8'd0);
        seg(1, "p1_r3", b, 5, 5, 1'b0, 1'b1, 8'd3);
        seg(1, "p1_r2", b, 6, 6, 1'b0, 1'b1, 8'd2);
        seg(1, "p1_r1", b, 7, 7, 1'b0, 1'b1, 8'd1);
        seg(1, "p1_n3_done", b, 8, 9, 1'b1, 1'b0, 8'd0);
        pulse1(b + 0, 1'b1, 1'b0, 8'd1);
        pulse1(b + 3, 1'b0, 1'b1, 8'd0);
        pulse1(b + 5, 1'b1, 1'b0, 8'd3);
        wait_edge(b + 10);

        for (int k = 0; k < 60 && (q4.size() > 0 || q1.size() > 0); k++) begin
            @(posedge clk);
        end
        if (q4.size() > 0 || q1.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q4.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_timer.md
# delay_timer

- Programmable one-shot delay timer with a built-in prescaler.
- Sits directly upstream of the Fibonacci control FSM: each t*_start_out pulse from the controller drives one instance's start_in, and that instance's int_out drives the matching t*_int_in.
- Paces the sequence shown on the LEDs, e.g. hold time per displayed term.
- One instance per timer channel (t0, t1, t2), each with its own delay.

## Interface

Parameters:
- PRESCALE, default 12000: clock cycles per tick (1 ms at 12 MHz); must be ≥ 1.
- COUNT_WIDTH, default 16: width of the tick counter, ticks_in and remaining_out; must be ≥ 1.

Ports:
- clock_in, input, 1: single clock, all state updates on the rising edge.
- reset_in, input, 1: reset is synchronous and active-low.
- start_in, input, 1: start or restart request, sampled each edge.
- abort_in, input, 1: cancel request, sampled each edge.
- ticks_in, input, COUNT_WIDTH: delay length in ticks, sampled only on an edge where start is accepted.
- int_out, output, 1: expiry flag, level, held until start_in or abort_in.
- busy_out, output, 1: high while counting.
- remaining_out, output, COUNT_WIDTH: ticks left in the current delay.

## Operation

States: IDLE, RUN, DONE. All outputs are registered.

Reset (reset_in = 0 at an edge):
- state IDLE, int_out 0, busy_out 0, remaining_out 0, prescale counter 0.
- Reset overrides everything, including mid-count; no expiry is reported for an aborted run.

IDLE:
- start_in = 1 and ticks_in ≠ 0: go to RUN, remaining ← ticks_in, prescale counter ← 0, busy_out ← 1.
- start_in = 1 and ticks_in = 0: go to DONE directly, int_out ← 1, remaining stays 0.
- abort_in alone: no effect.

RUN:
- Prescale counter increments each cycle and wraps from PRESCALE−1 to 0. The wrap is a "tick".
- On a tick, remaining decrements.
- Tick with remaining = 1: remaining ← 0, go to DONE, int_out ← 1, busy_out ← 0.
- start_in = 1: restart. Reload remaining from ticks_in, clear the prescale counter; the ticks_in = 0 rule from IDLE applies.
- abort_in = 1: go to IDLE, remaining ← 0, busy_out ← 0, int_out stays 0.

DONE:
- int_out holds 1, busy_out 0.
- start_in: behaves as from IDLE, and int_out ← 0 at the same edge unless ticks_in = 0.
- abort_in: go to IDLE, int_out ← 0.

Simultaneous events:
- abort_in and start_in together: abort wins in every state.
- start_in in RUN on the same edge as the final tick: restart wins; no int_out pulse.

Widths:
- Counter and prescaler never wrap below 0.
- Prescale counter width is clog2(PRESCALE), minimum 1.

## Timing

- Start accepted at edge k with ticks_in = N ≥ 1: int_out rises at edge k + N·PRESCALE. No earlier or later by any cycle.
- busy_out is high from edge k through edge k + N·PRESCALE − 1.
- remaining_out equals N − j after edge k + j·PRESCALE.
- ticks_in = 0: int_out rises at edge k.
- Clearing int_out (start or abort at edge m): int_out is low after edge m.
- The controller may assert start_in for one cycle or hold it; while held in RUN it restarts every cycle, so the controller must pulse it.

## Structure

- Shared package fib_pkg holds:
  - state encodings TMR_IDLE = 2'd0, TMR_RUN = 2'd1, TMR_DONE = 2'd2;
  - the default 1 ms PRESCALE constant, reused by all three timer instances.
- One sub-module is natural: tick_gen (prescale counter).
  - Inputs: clear, enable.
  - Output: one-cycle tick on wrap.
- The FSM and the tick counter stay in delay_timer.
- Elaboration check: PRESCALE ≥ 1 and COUNT_WIDTH ≥ 1.

## Test plan

All scenarios use PRESCALE = 4, COUNT_WIDTH = 8.

- Basic: start at edge 10 with ticks_in = 3 → busy_out high on edges 10–21; int_out rises at edge 22; remaining_out reads 3, 2, 1, 0 after edges 10, 14, 18, 22.
- Zero and hold: start with ticks_in = 0 at edge 5 → int_out high at edge 5, busy_out never high. int_out then holds for 20 cycles until start with ticks_in = 1 at edge 25 → int_out low after edge 25, rises again at edge 29.
- Restart: start with ticks_in = 5 at edge 0, start again with ticks_in = 2 at edge 7 → int_out rises at edge 15, not at edge 20.
- Abort and priority:
  - start and abort together at edge 3 while in RUN → IDLE, remaining_out 0, int_out never asserts.
  - abort in DONE clears int_out at the next edge.
- Reset mid-operation: reset_in low for one cycle at edge 6 of a ticks_in = 4 run → all outputs 0 after edge 6, no int_out afterwards. A new start after reset times correctly.
- PRESCALE = 1 corner: ticks_in = 1 → int_out rises exactly one edge after start is accepted.
